axis_downsizer: RTL and testbench

- Parametrised single-clock AXI-Stream width downsizer. It splits one wide PL beat (default 128 b) into N = IN_W/OUT_W narrow beats (default 32 b) for the PS-bound path.
- It is the next generation of the PL-to-PS converter, adding these over the fixed 128->32 version:
  - generic widths;
  - selectable lane order;
  - lane-granular keep for partial beats;
  - tlast propagation;
  - no-bubble back-to-back throughput.
- It sits between the adc_ctrl output FIFO (axis_sync_fifo) and the PS-side FIFO or CDC stage.

---
 rtl/rfsoc_config.sv | 25 ++
 rtl/axis_downsizer.sv | 123 ++++++++++++
 tb/tb_axis_downsizer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/rfsoc_config.sv
// Shared RFSoC data-path constants and helpers for the PL<->PS stream plumbing.
package rfsoc_config;

  localparam int PL_AXIS_W = 128;
  localparam int PS_AXIS_W = 32;

  // keep_count takes a fixed-width vector, so callers zero-extend narrower keeps.
  localparam int MAX_LANES = 64;
  localparam int KC_W      = $clog2(MAX_LANES) + 1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_EMIT  = 1'b1
  } ds_state_e;

  function automatic logic [KC_W-1:0] keep_count(input logic [MAX_LANES-1:0] keep);
    logic [KC_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n = n + KC_W'(keep[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/axis_downsizer.sv
// AXI-Stream width downsizer: one IN_W beat becomes up to N = IN_W/OUT_W OUT_W beats,
// with lane-granular keep, tlast on the final lane and zero-bubble beat chaining.
module axis_downsizer
  import rfsoc_config::*;
#(
  parameter int IN_W      = PL_AXIS_W,
  parameter int OUT_W     = PS_AXIS_W,
  parameter bit MSB_FIRST = 1'b0,
  localparam int N        = IN_W / OUT_W,
  localparam int IDX_W    = (N > 1) ? $clog2(N) : 1,
  localparam int CNT_W    = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  s_axis_tdata,
  input  logic [N-1:0]     s_axis_tkeep,
  input  logic             s_axis_tlast,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  output logic [OUT_W-1:0] m_axis_tdata,
  output logic             m_axis_tlast,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             busy,
  output logic             keep_err
);

  if ((IN_W % OUT_W) != 0 || N < 2 || N > MAX_LANES) begin : g_bad_cfg
    $error("axis_downsizer: IN_W=%0d must be a multiple of OUT_W=%0d with 2..%0d lanes",
           IN_W, OUT_W, MAX_LANES);
  end

  ds_state_e        state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [IN_W-1:0]  data_q, data_d;
  logic             keep_err_q, keep_err_d;

  logic             hold_valid;
  logic             last_lane;
  logic             m_fire;
  logic             s_fire;
  logic [KC_W-1:0]  kc_full;
  logic [CNT_W-1:0] keep_cnt;
  logic [IDX_W-1:0] sel;
  logic [OUT_W-1:0] lane [N];

  assign kc_full  = keep_count(MAX_LANES'(s_axis_tkeep));
  assign keep_cnt = CNT_W'(kc_full);

  assign hold_valid = (state_q == ST_EMIT);
  assign last_lane  = ({1'b0, idx_q} == (cnt_q - CNT_W'(1)));
  assign m_fire     = hold_valid & m_axis_tready;

  // Ready depends on m_axis_tready so the next beat loads on the final lane's transfer.
  assign s_axis_tready = !hold_valid | (m_fire & last_lane);
  assign s_fire        = s_axis_tvalid & s_axis_tready;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign lane[gi] = data_q[gi*OUT_W +: OUT_W];
  end

  assign sel = MSB_FIRST ? (IDX_W'(N - 1) - idx_q) : idx_q;

  assign m_axis_tdata  = lane[sel];
  assign m_axis_tvalid = hold_valid;
  assign m_axis_tlast  = hold_valid & last_q & last_lane;
  assign busy          = hold_valid;
  assign keep_err      = keep_err_q;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    data_d     = data_q;
    keep_err_d = 1'b0;

    if (m_fire) begin
      if (last_lane) begin
        state_d = ST_EMPTY;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    if (s_fire) begin
      data_d = s_axis_tdata;
      last_d = s_axis_tlast;
      cnt_d  = keep_cnt;
      idx_d  = '0;
      if (keep_cnt != '0) begin
        state_d = ST_EMIT;
      end else begin
        // Empty beat: swallowed whole, including any tlast it carried.
        state_d    = ST_EMPTY;
        last_d     = 1'b0;
        keep_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      idx_q      <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      data_q     <= '0;
      keep_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      data_q     <= data_d;
      keep_err_q <= keep_err_d;
    end
  end

endmodule

// File: tb/tb_axis_downsizer.sv
// Bench: LSB-first and MSB-first downsizers driven by one stream, checked against
// a queue of expected narrow beats derived from keep popcount and lane order.
module tb_axis_downsizer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] s_data;
  logic [3:0]   s_keep;
  logic         s_last;
  logic         s_valid;
  logic         m_ready;

  logic         rdy0, rdy1, tl0, tl1, tv0, tv1, bz0, bz1, ke0, ke1;
  logic [31:0]  td0, td1;

  always #5 clk = ~clk;

  axis_downsizer #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1'b0)) dut0 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tvalid(s_valid), .s_axis_tready(rdy0),
    .m_axis_tdata(td0), .m_axis_tlast(tl0), .m_axis_tvalid(tv0),
    .m_axis_tready(m_ready), .busy(bz0), .keep_err(ke0)
  );

  axis_downsizer #(.IN_W(128), .OUT_W(32), .MSB_FIRST(1'b1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tvalid(s_valid), .s_axis_tready(rdy1),
    .m_axis_tdata(td1), .m_axis_tlast(tl1), .m_axis_tvalid(tv1),
    .m_axis_tready(m_ready), .busy(bz1), .keep_err(ke1)
  );

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic        last;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [127:0] D  = 128'h00001111222233334444555566667777;
  localparam logic [127:0] D2 = D + {8{16'h8888}};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs before the edge, advance the model on the edge, check keep_err after.
  task automatic step(output bit acc);
    bit   xfer;
    bit   exp_rdy;
    bit   exp_kerr;
    int   cnt;
    exp_t e;
    #1;
    exp_rdy = (q.size() == 0) || (q.size() == 1 && m_ready);
    check("tready0", rdy0, exp_rdy);
    check("tready1", rdy1, exp_rdy);
    check("tvalid0", tv0, q.size() != 0);
    check("tvalid1", tv1, q.size() != 0);
    check("busy0", bz0, q.size() != 0);
    check("busy1", bz1, q.size() != 0);
    if (q.size() != 0) begin
      check("tdata0", td0, q[0].d0);
      check("tdata1", td1, q[0].d1);
      check("tlast0", tl0, q[0].last);
      check("tlast1", tl1, q[0].last);
    end
    acc  = s_valid && exp_rdy;
    xfer = (q.size() != 0) && m_ready;
    @(posedge clk);
    if (xfer) void'(q.pop_front());
    exp_kerr = 1'b0;
    if (acc) begin
      cnt = $countones(s_keep);
      if (cnt == 0) exp_kerr = 1'b1;
      for (int j = 0; j < cnt; j++) begin
        e.d0   = s_data[j*32 +: 32];
        e.d1   = s_data[(3-j)*32 +: 32];
        e.last = s_last && (j == cnt - 1);
        q.push_back(e);
      end
    end
    #1;
    check("keep_err0", ke0, exp_kerr);
    check("keep_err1", ke1, exp_kerr);
    @(negedge clk);
  endtask

  initial begin
    bit acc;
    int k;
    int kc;

    rst = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tvalid", tv0, 1'b0);
    check("rst_tready", rdy0, 1'b1);
    check("rst_busy", bz0, 1'b0);
    check("rst_kerr", ke0, 1'b0);
    check("rst_tlast", tl1, 1'b0);
    check("rst_tdata", td0, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(acc);

    // Full beat, no tlast, then full beat with tlast
    s_data = D; s_keep = 4'hF; s_last = 1'b0; s_valid = 1'b1;
    step(acc); s_valid = 1'b0;
    repeat (5) step(acc);
    s_last = 1'b1; s_valid = 1'b1;
    step(acc); s_valid = 1'b0;
    repeat (5) step(acc);

    // Back-to-back beats
    s_data = D; s_last = 1'b0; s_valid = 1'b1; k = 0;
    for (int i = 0; i < 12 && k < 2; i++) begin
      step(acc);
      if (acc) begin k++; s_data = D2; end
    end
    s_valid = 1'b0;
    repeat (9) step(acc);

    // Partial beat followed immediately by another
    s_data = D; s_keep = 4'b0011; s_last = 1'b1; s_valid = 1'b1; k = 0;
    for (int i = 0; i < 12 && k < 2; i++) begin
      step(acc);
      if (acc) begin k++; s_data = D2; s_keep = 4'hF; s_last = 1'b0; end
    end
    s_valid = 1'b0;
    repeat (5) step(acc);

    // Backpressure with toggling m_ready
    s_data = D; s_keep = 4'hF; s_last = 1'b1; s_valid = 1'b1;
    step(acc); s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m_ready = (i % 2 == 0);
      step(acc);
    end
    m_ready = 1'b1;

    // Zero-keep beat
    s_data = D2; s_keep = 4'h0; s_last = 1'b1; s_valid = 1'b1;
    step(acc); s_valid = 1'b0;
    repeat (2) step(acc);

    // Randomized traffic with random backpressure
    acc = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (!s_valid || acc) begin
        s_valid = ($urandom_range(0, 3) != 0);
        s_data  = {$urandom, $urandom, $urandom, $urandom};
        kc      = $urandom_range(0, 4);
        s_keep  = 4'((1 << kc) - 1);
        s_last  = 1'($urandom_range(0, 1));
      end
      m_ready = ($urandom_range(0, 3) != 0);
      step(acc);
    end
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (6) step(acc);

    // Asynchronous reset after two of four lanes
    s_data = D; s_keep = 4'hF; s_last = 1'b1; s_valid = 1'b1;
    step(acc); s_valid = 1'b0;
    repeat (2) step(acc);
    #2 rst = 1'b0;
    #1;
    check("arst_tvalid0", tv0, 1'b0);
    check("arst_tvalid1", tv1, 1'b0);
    check("arst_busy", bz0, 1'b0);
    check("arst_tready", rdy1, 1'b1);
    check("arst_tdata", td0, 32'h0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    step(acc);
    s_data = D2; s_keep = 4'hF; s_last = 1'b0; s_valid = 1'b1;
    step(acc); s_valid = 1'b0;
    repeat (5) step(acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
